// File: rtl/bist_pkg.sv
// Shared types and default sizing for the BIST session scheduler.
// One pattern generator/MISR pair is time-shared across several CUTs.
package bist_pkg;

   localparam int DEF_N_CUT     = 4;
   localparam int DEF_PAT_COUNT = 15;
   localparam int DEF_SIG_W     = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_RUN,
      ST_CAPTURE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/bist_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the next CUT.
// Purely combinational; o_valid flags a non-empty mask.
module bist_prio_enc #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] i_mask,
   output logic [W-1:0] o_idx,
   output logic         o_valid
);

   always_comb begin
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_mask[i]) o_idx = W'(i);
      end
   end

   assign o_valid = |i_mask;

endmodule

// File: rtl/bist_session_scheduler.sv
// Sequences INIT/RUN/CAPTURE over each enabled CUT in index order
// and records a per-CUT pass/fail flag from the shared MISR.
module bist_session_scheduler
   import bist_pkg::*;
#(
   parameter int N_CUT     = DEF_N_CUT,
   parameter int PAT_COUNT = DEF_PAT_COUNT,
   parameter int SIG_W     = DEF_SIG_W,
   localparam int SEL_W    = (N_CUT > 1) ? $clog2(N_CUT) : 1,
   localparam int CNT_W    = $clog2(PAT_COUNT + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic [N_CUT-1:0]       cut_en,
   input  logic [SIG_W-1:0]       misr_sig,
   input  logic [N_CUT*SIG_W-1:0] golden_sigs,
   output logic [SEL_W-1:0]       cut_sel,
   output logic                   lfsr_load,
   output logic                   lfsr_en,
   output logic                   misr_clr,
   output logic                   misr_en,
   output logic                   testmode,
   output logic                   busy,
   output logic                   done,
   output logic [N_CUT-1:0]       fail_vec,
   output logic                   fault_detected
);

   state_t             r_state;
   state_t             w_next;
   logic [N_CUT-1:0]   r_pend;
   logic [SEL_W-1:0]   r_sel;
   logic [CNT_W-1:0]   r_cnt;
   logic [N_CUT-1:0]   r_fail;
   logic               r_fault;

   logic [N_CUT-1:0]   w_rem;
   logic [N_CUT-1:0]   w_enc_in;
   logic [SEL_W-1:0]   w_idx;
   logic               w_valid;
   logic               w_mis;
   logic [N_CUT-1:0]   w_fail_nx;
   logic               w_accept;
   logic               w_last;

   assign w_rem    = r_pend & ~(N_CUT'(1) << r_sel);
   // IDLE picks the first CUT from cut_en; afterwards from what remains.
   assign w_enc_in = (r_state == ST_IDLE) ? cut_en : w_rem;
   assign w_mis    = misr_sig != golden_sigs[SIG_W*r_sel +: SIG_W];
   assign w_accept = start && !abort;
   assign w_last   = r_cnt == CNT_W'(PAT_COUNT - 1);

   bist_prio_enc #(
      .N (N_CUT),
      .W (SEL_W)
   ) u_enc (
      .i_mask  (w_enc_in),
      .o_idx   (w_idx),
      .o_valid (w_valid)
   );

   always_comb begin
      w_fail_nx        = r_fail;
      w_fail_nx[r_sel] = w_mis;
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) w_next = w_valid ? ST_INIT : ST_DONE;
         end
         ST_INIT: begin
            w_next = abort ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
            if (abort)       w_next = ST_IDLE;
            else if (w_last) w_next = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (abort)        w_next = ST_IDLE;
            else if (w_valid) w_next = ST_INIT;
            else              w_next = ST_DONE;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pend  <= '0;
         r_sel   <= '0;
         r_cnt   <= '0;
         r_fail  <= '0;
         r_fault <= 1'b0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_pend  <= cut_en;
                  r_fail  <= '0;
                  r_fault <= 1'b0;
                  if (w_valid) r_sel <= w_idx;
               end
            end
            ST_INIT: r_cnt <= '0;
            ST_RUN:  r_cnt <= r_cnt + CNT_W'(1);
            ST_CAPTURE: begin
               if (!abort) begin
                  r_fail  <= w_fail_nx;
                  r_fault <= |w_fail_nx;
                  r_pend  <= w_rem;
                  if (w_valid) r_sel <= w_idx;
               end
            end
            default: ;
         endcase
      end
   end

   assign lfsr_load      = r_state == ST_INIT;
   assign misr_clr       = r_state == ST_INIT;
   assign lfsr_en        = r_state == ST_RUN;
   assign misr_en        = r_state == ST_RUN;
   assign busy           = (r_state == ST_INIT) || (r_state == ST_RUN) ||
                           (r_state == ST_CAPTURE);
   assign testmode       = busy;
   assign done           = r_state == ST_DONE;
   assign cut_sel        = r_sel;
   assign fail_vec       = r_fail;
   assign fault_detected = r_fault;

endmodule

// File: doc/bist_session_scheduler.md
BIST_SESSION_SCHEDULER -- requirements
Module: bist_session_scheduler

Interface
REQ-001 SHALL have parameter N_CUT, default 4, number of circuits-under-test sharing one pattern generator/MISR pair.
REQ-002 SHALL have parameter PAT_COUNT, default 15, number of RUN cycles per CUT (4-bit LFSR period).
REQ-003 SHALL have parameter SIG_W, default 4, MISR signature width.
REQ-004 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  session request, sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  terminate session, returns to IDLE.
REQ-008 SHALL have port cut_en  input  N_CUT  mask of CUTs to test, captured at accepted start.
REQ-009 SHALL have port misr_sig  input  SIG_W  current signature from shared MISR.
REQ-010 SHALL have port golden_sigs  input  N_CUT*SIG_W  expected signature per CUT, slice i for CUT i.
REQ-011 SHALL have port cut_sel  output  clog2(N_CUT)  CUT currently routed to LFSR/MISR.
REQ-012 SHALL have ports lfsr_load, lfsr_en, misr_clr, misr_en  output  1 each  shared-datapath strobes.
REQ-013 SHALL have ports testmode, busy, done  output  1 each; done is a one-cycle pulse.
REQ-014 SHALL have ports fail_vec  output  N_CUT  per-CUT failure flags; fault_detected  output  1  OR of fail_vec.

Function
REQ-015 SHALL implement FSM states IDLE, INIT, RUN, CAPTURE, DONE.
REQ-016 IDLE: start=1 with cut_en!=0 -> INIT; pending mask <= cut_en, fail_vec <= 0, cut_sel <= lowest set bit of cut_en.
REQ-017 IDLE: start=1 with cut_en==0 -> DONE directly; fail_vec <= 0.
REQ-018 INIT (1 cycle): lfsr_load=1, misr_clr=1; pattern counter <= 0; next RUN.
REQ-019 RUN: lfsr_en=1, misr_en=1 for exactly PAT_COUNT cycles; counter increments each cycle; after count PAT_COUNT-1 -> CAPTURE.
REQ-020 CAPTURE (1 cycle): fail_vec[cut_sel] <= (misr_sig != golden slice cut_sel); clear pending bit cut_sel.
REQ-021 CAPTURE: if remaining pending mask != 0 -> INIT with cut_sel <= lowest remaining set bit; else -> DONE.
REQ-022 DONE (1 cycle): done=1; next IDLE.
REQ-023 Latency: k enabled CUTs -> DONE entered k*(PAT_COUNT+2)+1 cycles after the start-sampling edge.
REQ-024 testmode=busy=1 in INIT, RUN, CAPTURE; 0 in IDLE, DONE.
REQ-025 All datapath strobes 0 outside the state that drives them.
REQ-026 fault_detected = |fail_vec, registered alongside fail_vec; holds until next accepted start or reset.
REQ-027 start while busy SHALL be ignored; cut_en changes after acceptance SHALL not affect the session.
REQ-028 abort in INIT/RUN/CAPTURE -> IDLE next cycle; no done pulse; fail_vec keeps bits already captured; abort has priority over CAPTURE update.
REQ-029 abort in IDLE or DONE SHALL have no effect; start and abort together in IDLE -> remain IDLE.

Reset
REQ-030 reset SHALL force IDLE, cut_sel=0, counter=0, pending=0, fail_vec=0, fault_detected=0, all strobes/testmode/busy/done=0 on next edge; reset overrides start and abort.
REQ-031 reset mid-session SHALL discard all results without a done pulse.

Structure
REQ-032 Package bist_pkg SHALL hold the state enum and default constants N_CUT, PAT_COUNT, SIG_W.
REQ-033 Lowest-set-bit selection SHALL be a sub-module bist_prio_enc (mask in, index and valid out, combinational).
REQ-034 Counter width SHALL be clog2(PAT_COUNT+1); no other sub-modules.

Verification
REQ-035 cut_en=4'b1111, all misr_sig==golden -> cut_sel 0,1,2,3 in order, done at cycle 4*17+1=69, fail_vec=0, fault_detected=0.
REQ-036 cut_en=4'b0101, CUT2 misr_sig mismatched in CAPTURE -> only CUT0, CUT2 tested, fail_vec=4'b0100, fault_detected=1, done at cycle 35.
REQ-037 cut_en=0, start=1 -> DONE next cycle, done pulse, fail_vec=0, no lfsr/misr strobes.
REQ-038 abort asserted at RUN cycle 7 of CUT1 (cut_en=4'b0011, CUT0 failed) -> IDLE next cycle, no done, fail_vec=4'b0001.
REQ-039 reset asserted mid-RUN, then start with cut_en=4'b1000 -> all outputs 0 after reset; new session tests only CUT3, done at cycle 18.
REQ-040 start re-pulsed during RUN and cut_en toggled -> session sequence and timing unchanged from REQ-035.
